// File: rtl/avion_io_port_if.sv
// avion_io_port_if
// Bus bundle between the avion_cpu memory bus and the avion_io_port peripheral.
//   MAR      : bus address from the CPU
//   RAMWr    : bus write strobe
//   MDRIn    : bus write data
//   io_hit   : combinational window hit (top level gates RAM write with ~io_hit)
//   io_hit_q : registered hit, selects io_rdata onto MDROut
//   io_rdata : registered read data
// master = CPU / bus side, slave = peripheral side.
interface avion_io_port_if #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 10
);
    logic [ADDRESS_WIDTH-1:0] MAR;
    logic                     RAMWr;
    logic [DATA_WIDTH-1:0]    MDRIn;
    logic                     io_hit;
    logic                     io_hit_q;
    logic [DATA_WIDTH-1:0]    io_rdata;

    modport master (
        output MAR, RAMWr, MDRIn,
        input  io_hit, io_hit_q, io_rdata
    );

    modport slave (
        input  MAR, RAMWr, MDRIn,
        output io_hit, io_hit_q, io_rdata
    );
endinterface

// File: rtl/avion_io_port.sv
// avion_io_port
// Memory-mapped transmit peripheral on the avion_cpu bus. A 4-word window at
// BASE_ADDR exposes TXDATA (0), STATUS (1), BAUDDIV (2) and LED (3). Bytes
// written to TXDATA go through a small FIFO and are serialized as 8N1 frames
// on tx (8E1-style frame with an even-parity bit when AVION_IO_PARITY_EN is
// defined).
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : avion_io_port_if.slave (MAR, RAMWr, MDRIn, io_hit, io_hit_q, io_rdata)
//   tx    : serial output, idles high
//   leds  : LED register value
// Optional feature macro: AVION_IO_PARITY_EN
module avion_io_port #(
    parameter int ADDRESS_WIDTH = 6,
    parameter int DATA_WIDTH    = 10,
    parameter int BASE_ADDR     = 60,
    parameter int FIFO_DEPTH    = 4,
    parameter int DEFAULT_DIV   = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    avion_io_port_if.slave        bus,
    output logic                  tx,
    output logic [DATA_WIDTH-1:0] leds
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ADDRESS_WIDTH-1:0] BASE_C = ADDRESS_WIDTH'(BASE_ADDR);
    localparam logic [9:0] DEF_DIV_C  = 10'(DEFAULT_DIV);
    localparam logic [2:0] DEPTH_C    = 3'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Wrap a FIFO pointer at FIFO_DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            r = '0;
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

`ifdef AVION_IO_PARITY_EN
    // Even parity: the bit that makes the total number of ones even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    // Bus decode
    logic                  hit_s;
    logic [1:0]            off_s;
    logic                  wr_s;
    logic                  push_req_s;
    logic                  push_ok_s;
    logic                  stat_wr_s;
    logic                  div_wr_s;
    logic                  led_wr_s;

    // Registers
    logic [9:0]            div_r;
    logic [DATA_WIDTH-1:0] leds_r;
    logic                  ovf_r;
    logic                  hit_q_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [DATA_WIDTH-1:0] rd_mux_s;
    logic [DATA_WIDTH-1:0] status_s;

    // FIFO
    logic [7:0]            fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [2:0]            count_r;
    logic                  empty_s;
    logic                  full_s;
    logic [7:0]            head_s;
    logic                  pop_s;

    // Serializer
    state_t                state_r;
    state_t                state_next_s;
    logic [9:0]            bit_cnt_r;
    logic [9:0]            cnt_next_s;
    logic [2:0]            bit_idx_r;
    logic [2:0]            idx_next_s;
    logic [7:0]            shift_r;
    logic [7:0]            shift_next_s;
    logic                  tx_r;
    logic                  tx_next_s;
    logic                  busy_s;
`ifdef AVION_IO_PARITY_EN
    logic                  parity_r;
    logic                  parity_next_s;
`endif

    // Address window decode; BASE_ADDR is 4-aligned so the upper bits select.
    always_comb begin
        hit_s      = (bus.MAR[ADDRESS_WIDTH-1:2] == BASE_C[ADDRESS_WIDTH-1:2]);
        off_s      = bus.MAR[1:0];
        wr_s       = hit_s && bus.RAMWr;
        push_req_s = wr_s && (off_s == 2'd0);
        stat_wr_s  = wr_s && (off_s == 2'd1);
        div_wr_s   = wr_s && (off_s == 2'd2);
        led_wr_s   = wr_s && (off_s == 2'd3);
        empty_s    = (count_r == 3'd0);
        full_s     = (count_r == DEPTH_C);
        head_s     = fifo_mem_r[rd_ptr_r];
        // A simultaneous pop frees the slot, so a push into a full FIFO is accepted.
        push_ok_s  = push_req_s && (!full_s || pop_s);
        busy_s     = (state_r != ST_IDLE);
    end

    assign bus.io_hit   = hit_s;
    assign bus.io_hit_q = hit_q_r;
    assign bus.io_rdata = rdata_r;
    assign tx           = tx_r;
    assign leds         = leds_r;

    // STATUS word assembly and read data mux.
    always_comb begin
        status_s      = '0;
        status_s[0]   = busy_s;
        status_s[1]   = empty_s;
        status_s[2]   = full_s;
        status_s[3]   = ovf_r;
        status_s[6:4] = count_r;
        case (off_s)
            2'd0:    rd_mux_s = '0;
            2'd1:    rd_mux_s = status_s;
            2'd2:    rd_mux_s = DATA_WIDTH'(div_r);
            2'd3:    rd_mux_s = leds_r;
            default: rd_mux_s = '0;
        endcase
    end

    // Registered read port: one-cycle latency, old value on same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q_r <= 1'b0;
            rdata_r <= '0;
        end else begin
            hit_q_r <= hit_s;
            rdata_r <= hit_s ? rd_mux_s : '0;
        end
    end

    // Writable registers and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r  <= DEF_DIV_C;
            leds_r <= '0;
            ovf_r  <= 1'b0;
        end else begin
            if (div_wr_s) begin
                div_r <= 10'(bus.MDRIn);
            end
            if (led_wr_s) begin
                leds_r <= bus.MDRIn;
            end
            if (push_req_s && !push_ok_s) begin
                ovf_r <= 1'b1;
            end else if (stat_wr_s) begin
                ovf_r <= 1'b0;
            end
        end
    end

    // TX FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= 3'd0;
        end else begin
            if (push_ok_s) begin
                fifo_mem_r[wr_ptr_r] <= bus.MDRIn[7:0];
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Serializer next-state, counters and next tx level.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = bit_cnt_r;
        idx_next_s   = bit_idx_r;
        shift_next_s = shift_r;
        pop_s        = 1'b0;
        tx_next_s    = 1'b1;
`ifdef AVION_IO_PARITY_EN
        parity_next_s = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s        = 1'b1;
                    shift_next_s = head_s;
                    cnt_next_s   = div_r;
                    state_next_s = ST_START;
`ifdef AVION_IO_PARITY_EN
                    parity_next_s = even_parity(head_s);
`endif
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_cnt_r == 10'd0) begin
                    cnt_next_s   = div_r;
                    idx_next_s   = 3'd0;
                    state_next_s = ST_DATA;
                end else begin
                    cnt_next_s = bit_cnt_r - 10'd1;
                end
            end
            ST_DATA: begin
                if (bit_cnt_r == 10'd0) begin
                    cnt_next_s   = div_r;
                    shift_next_s = {1'b0, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
`ifdef AVION_IO_PARITY_EN
                        state_next_s = ST_PARITY;
`else
                        state_next_s = ST_STOP;
`endif
                    end else begin
                        idx_next_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    cnt_next_s = bit_cnt_r - 10'd1;
                end
            end
`ifdef AVION_IO_PARITY_EN
            ST_PARITY: begin
                if (bit_cnt_r == 10'd0) begin
                    cnt_next_s   = div_r;
                    state_next_s = ST_STOP;
                end else begin
                    cnt_next_s = bit_cnt_r - 10'd1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_cnt_r == 10'd0) begin
                    // Chain straight into the next frame when data is waiting.
                    if (!empty_s) begin
                        pop_s        = 1'b1;
                        shift_next_s = head_s;
                        cnt_next_s   = div_r;
                        state_next_s = ST_START;
`ifdef AVION_IO_PARITY_EN
                        parity_next_s = even_parity(head_s);
`endif
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    cnt_next_s = bit_cnt_r - 10'd1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase

        case (state_next_s)
            ST_START:  tx_next_s = 1'b0;
            ST_DATA:   tx_next_s = shift_next_s[0];
`ifdef AVION_IO_PARITY_EN
            ST_PARITY: tx_next_s = parity_next_s;
`endif
            default:   tx_next_s = 1'b1;
        endcase
    end

    // Serializer state register; tx is registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 10'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            tx_r      <= 1'b1;
`ifdef AVION_IO_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            state_r   <= state_next_s;
            bit_cnt_r <= cnt_next_s;
            bit_idx_r <= idx_next_s;
            shift_r   <= shift_next_s;
            tx_r      <= tx_next_s;
`ifdef AVION_IO_PARITY_EN
            parity_r  <= parity_next_s;
`endif
        end
    end

endmodule

// File: tb/tb_avion_io_port.sv
// tb_avion_io_port
// Directed self-checking bench for avion_io_port. Expected read data and
// expected tx levels are queued when stimulus is driven and compared when the
// DUT produces them. Inputs change and outputs are sampled on the falling edge.
module tb_avion_io_port;

    localparam int AW = 6;
    localparam int DW = 10;
    localparam logic [5:0] A_TX  = 6'd60;
    localparam logic [5:0] A_ST  = 6'd61;
    localparam logic [5:0] A_DIV = 6'd62;
    localparam logic [5:0] A_LED = 6'd63;
    localparam logic [5:0] A_OUT = 6'd0;
`ifdef AVION_IO_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          tx;
    logic [DW-1:0] leds;

    avion_io_port_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    avion_io_port #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .BASE_ADDR    (60),
        .FIFO_DEPTH   (4),
        .DEFAULT_DIV  (15)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave),
        .tx   (tx),
        .leds (leds)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] exp_rd_q [$];
    logic        exp_tx_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [DW-1:0] d);
        bus.MAR   = a;
        bus.MDRIn = d;
        bus.RAMWr = 1'b1;
        @(negedge clk);
        bus.RAMWr = 1'b0;
        bus.MAR   = A_OUT;
    endtask

    task automatic bus_read(input string tag, input logic [5:0] a, input logic [31:0] exp);
        exp_rd_q.push_back(exp);
        bus.MAR = a;
        @(negedge clk);
        chk(tag, 32'(bus.io_rdata), exp_rd_q.pop_front());
        chk({tag, "_hitq"}, 32'(bus.io_hit_q), 32'd1);
        bus.MAR = A_OUT;
    endtask

    // Reference frame: start, 8 data bits LSB first, [even parity], stop.
    task automatic push_frame(input logic [7:0] b, input int div);
        logic bits [$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (NBITS == 11) bits.push_back(^b);
        bits.push_back(1'b1);
        foreach (bits[j]) begin
            for (int k = 0; k <= div; k++) exp_tx_q.push_back(bits[j]);
        end
    endtask

    task automatic run_tx(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (exp_tx_q.size() == 0) begin
                chk({tag, "_qempty"}, 32'd1, 32'd0);
            end else begin
                chk($sformatf("%s_%0d", tag, i), 32'(tx), 32'(exp_tx_q.pop_front()));
            end
        end
    endtask

    initial begin
        logic low_seen;
        bus.MAR   = A_OUT;
        bus.RAMWr = 1'b0;
        bus.MDRIn = '0;

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_rdata", 32'(bus.io_rdata), 32'd0);
        chk("rst_hitq", 32'(bus.io_hit_q), 32'd0);
        rst_n = 1'b1;
        bus_read("rst_status", A_ST, 32'h002);
        bus_read("rst_div", A_DIV, 32'd15);

        // LED register write/read
        bus_write(A_LED, 10'h2A5);
        chk("led_out", 32'(leds), 32'h2A5);
        bus_read("led_rd", A_LED, 32'h2A5);
        bus_read("txdata_rd", A_TX, 32'h000);

        // Read during write to the same register returns the old value
        bus.MAR = A_LED; bus.MDRIn = 10'h155; bus.RAMWr = 1'b1;
        @(negedge clk);
        bus.RAMWr = 1'b0; bus.MAR = A_OUT;
        chk("rw_old", 32'(bus.io_rdata), 32'h2A5);
        chk("rw_leds", 32'(leds), 32'h155);

        // Single frame with STATUS watched every cycle
        bus_write(A_DIV, 10'd3);
        bus_read("div_rd", A_DIV, 32'd3);
        push_frame(8'h55, 3);
        exp_rd_q.push_back(32'h010);
        for (int i = 1; i < NBITS * 4; i++) exp_rd_q.push_back(32'h003);
        bus_write(A_TX, 10'h055);
        chk("f1_pre", 32'(tx), 32'd1);
        bus.MAR = A_ST;
        for (int i = 0; i < NBITS * 4; i++) begin
            @(negedge clk);
            chk($sformatf("f1_tx_%0d", i), 32'(tx), 32'(exp_tx_q.pop_front()));
            chk($sformatf("f1_st_%0d", i), 32'(bus.io_rdata), exp_rd_q.pop_front());
        end
        bus.MAR = A_OUT;
        @(negedge clk);
        chk("f1_idle", 32'(tx), 32'd1);
        bus_read("f1_status", A_ST, 32'h002);

        // Back-to-back frames, second byte pushed while the first is popped
        push_frame(8'hA3, 3);
        push_frame(8'h0F, 3);
        bus_write(A_TX, 10'h0A3);
        bus.MAR = A_TX; bus.MDRIn = 10'h00F; bus.RAMWr = 1'b1;
        @(negedge clk);
        bus.RAMWr = 1'b0; bus.MAR = A_OUT;
        chk("b2b_first", 32'(tx), 32'(exp_tx_q.pop_front()));
        run_tx("b2b", 2 * NBITS * 4 - 1);
        @(negedge clk);
        chk("b2b_idle", 32'(tx), 32'd1);
        bus_read("b2b_status", A_ST, 32'h002);

        // Out-of-window write and window edges
        bus.MAR = 6'd59;
        #1 chk("hit_59", 32'(bus.io_hit), 32'd0);
        bus.MAR = 6'd60;
        #1 chk("hit_60", 32'(bus.io_hit), 32'd1);
        bus.MAR = 6'd10; bus.MDRIn = 10'h3FF; bus.RAMWr = 1'b1;
        #1 chk("oow_hit", 32'(bus.io_hit), 32'd0);
        @(negedge clk);
        bus.RAMWr = 1'b0; bus.MAR = A_OUT;
        chk("oow_rdata", 32'(bus.io_rdata), 32'd0);
        chk("oow_hitq", 32'(bus.io_hit_q), 32'd0);
        chk("oow_leds", 32'(leds), 32'h155);
        chk("oow_tx", 32'(tx), 32'd1);
        bus_read("oow_div", A_DIV, 32'd3);
        bus_read("oow_status", A_ST, 32'h002);

        // Overflow: 6 consecutive pushes, one popped, four queued, one dropped
        bus_write(A_DIV, 10'd100);
        bus.MAR = A_TX; bus.RAMWr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.MDRIn = 10'(8'h10 + i);
            @(negedge clk);
        end
        bus.RAMWr = 1'b0; bus.MAR = A_OUT;
        bus_read("ovf_status", A_ST, 32'h04D);
        bus_write(A_ST, 10'h3FF);
        bus_read("ovf_clr", A_ST, 32'h045);
        chk("ovf_start", 32'(tx), 32'd0);

        // Reset mid-frame (start bit) clears FIFO and serializer
        #1 rst_n = 1'b0;
        #1 chk("ovf_rst_tx", 32'(tx), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read("ovf_rst_status", A_ST, 32'h002);

        // Reset during the 3rd data bit forces tx high immediately
        push_frame(8'h00, 15);
        bus_write(A_TX, 10'h000);
        run_tx("mf", 56);
        exp_tx_q.delete();
        #1 rst_n = 1'b0;
        #1 chk("mf_rst_tx", 32'(tx), 32'd1);
        chk("mf_rst_leds", 32'(leds), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_read("mf_status", A_ST, 32'h002);
        low_seen = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        chk("mf_no_frame", 32'(low_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
